// File: rtl/ddr3_lane_read_delay_trainer.sv
// ddr3_lane_read_delay_trainer: sweeps a lane's read delay line, finds the widest passing eye and parks at its centre.
module ddr3_lane_read_delay_trainer #(
   parameter int unsigned MAX_TAPS      = 128,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned SAMPLE_COUNT  = 16,
   parameter logic [7:0]  PATTERN       = 8'h55
) (
   input  logic       fab_clk_i,
   input  logic       arst_n_i,
   input  logic       train_start_i,
   input  logic [7:0] rx_data_i,
   input  logic       delay_line_out_of_range_i,
   output logic       delay_line_load_o,
   output logic       delay_line_move_o,
   output logic       delay_line_direction_o,
   output logic       eye_monitor_clear_flags_o,
   output logic       train_busy_o,
   output logic       train_done_o,
   output logic       train_fail_o,
   output logic [7:0] final_tap_o,
   output logic [7:0] window_width_o
);
   typedef enum logic [3:0] {IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, CENTER, DONE, FAIL} state_t;
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_COUNT - 1);
   localparam logic [7:0]  TAP_LAST    = 8'(MAX_TAPS - 1);
   state_t      state_q;
   logic [7:0]  tap_q, cur_start_q, cur_end_q, best_start_q, best_end_q, final_q, width_q;
   logic [8:0]  best_w_q, cur_w_d;
   logic [15:0] cnt_q;
   logic        open_q, pass_q, centering_q, start_prev_q;
   logic        load_q, move_q, dir_q, clr_q, busy_q, done_q, fail_q;
   logic [7:0]  target_d;
   logic        close_d, better_d, last_tap_d, restart_d;
   always_comb begin
      cur_w_d    = {1'b0, cur_end_q} - {1'b0, cur_start_q} + 9'd1;
      better_d   = cur_w_d > best_w_q;
      close_d    = open_q && ((state_q == EVAL && !pass_q) || (state_q == STEP && !move_q));
      target_d   = 8'(({1'b0, best_start_q} + {1'b0, best_end_q}) >> 1);
      last_tap_d = tap_q == TAP_LAST || delay_line_out_of_range_i;
      restart_d  = train_start_i && (state_q == IDLE ||
                   ((state_q == DONE || state_q == FAIL) && !start_prev_q));
   end
   always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= IDLE;
         tap_q        <= '0;
         cur_start_q  <= '0;
         cur_end_q    <= '0;
         best_start_q <= '0;
         best_end_q   <= '0;
         best_w_q     <= '0;
         cnt_q        <= '0;
         open_q       <= 1'b0;
         pass_q       <= 1'b0;
         centering_q  <= 1'b0;
         start_prev_q <= 1'b0;
         load_q       <= 1'b0;
         move_q       <= 1'b0;
         dir_q        <= 1'b0;
         clr_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fail_q       <= 1'b0;
         final_q      <= '0;
         width_q      <= '0;
      end else begin
         start_prev_q <= train_start_i;
         clr_q        <= load_q | move_q;
         if (restart_d) begin
            state_q      <= LOAD;
            load_q       <= 1'b1;
            move_q       <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            final_q      <= '0;
            width_q      <= '0;
            tap_q        <= '0;
            open_q       <= 1'b0;
            cur_start_q  <= '0;
            cur_end_q    <= '0;
            best_start_q <= '0;
            best_end_q   <= '0;
            best_w_q     <= '0;
            centering_q  <= 1'b0;
         end else begin
            case (state_q)
               LOAD: begin
                  load_q  <= 1'b0;
                  tap_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= SETTLE;
               end
               SETTLE: begin
                  cnt_q <= cnt_q == SETTLE_LAST ? '0 : cnt_q + 16'd1;
                  if (cnt_q == SETTLE_LAST) begin
                     pass_q  <= 1'b1;
                     state_q <= centering_q ? CENTER : SAMPLE;
                  end
               end
               SAMPLE: begin
                  pass_q <= pass_q && rx_data_i == PATTERN;
                  cnt_q  <= cnt_q == SAMPLE_LAST ? '0 : cnt_q + 16'd1;
                  if (cnt_q == SAMPLE_LAST) state_q <= EVAL;
               end
               EVAL: begin
                  if (pass_q) begin
                     open_q    <= 1'b1;
                     cur_end_q <= tap_q;
                     if (!open_q) cur_start_q <= tap_q;
                  end
                  // the move decision is taken here so the pulse is registered during STEP
                  move_q  <= !last_tap_d;
                  dir_q   <= 1'b1;
                  state_q <= STEP;
               end
               STEP: begin
                  if (move_q) begin
                     move_q  <= 1'b0;
                     tap_q   <= tap_q + 8'd1;
                     state_q <= SETTLE;
                  end else begin
                     centering_q <= 1'b1;
                     state_q     <= CENTER;
                  end
               end
               CENTER: begin
                  if (best_w_q == '0) begin
                     busy_q  <= 1'b0;
                     fail_q  <= 1'b1;
                     state_q <= FAIL;
                  end else if (move_q) begin
                     move_q  <= 1'b0;
                     tap_q   <= tap_q - 8'd1;
                     state_q <= SETTLE;
                  end else if (tap_q > target_d) begin
                     move_q <= 1'b1;
                     dir_q  <= 1'b0;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     final_q <= target_d;
                     width_q <= best_w_q[8] ? 8'hFF : best_w_q[7:0];
                     state_q <= DONE;
                  end
               end
               default: ;
            endcase
            if (close_d) begin
               open_q <= 1'b0;
               if (better_d) begin
                  best_start_q <= cur_start_q;
                  best_end_q   <= cur_end_q;
                  best_w_q     <= cur_w_d;
               end
            end
         end
      end
   end
   assign delay_line_load_o         = load_q;
   assign delay_line_move_o         = move_q;
   assign delay_line_direction_o    = dir_q;
   assign eye_monitor_clear_flags_o = clr_q;
   assign train_busy_o              = busy_q;
   assign train_done_o              = done_q;
   assign train_fail_o              = fail_q;
   assign final_tap_o               = final_q;
   assign window_width_o            = width_q;
endmodule

// File: doc/ddr3_lane_read_delay_trainer.md
Name: ddr3_lane_read_delay_trainer

Overview:
- Per-lane read-data delay training controller for the DDR3 PHY.
- Sits directly upstream of a lane's read-training IOD, on the delay-line control pins, and consumes that IOD's deserialised RX_DATA and DELAY_LINE_OUT_OF_RANGE.
- Sweeps the input delay line tap by tap, checks each tap against a known training byte, finds the longest passing window, then steps the delay line back to the window centre and reports the result.

Parameters:
- MAX_TAPS, 128: number of delay taps swept (tap indices 0..MAX_TAPS-1; range 2..256).
- SETTLE_CYCLES, 8: FAB_CLK cycles to wait after every load or move before sampling (minimum 1).
- SAMPLE_COUNT, 16: consecutive RX_DATA words compared per tap (minimum 1).
- PATTERN, 8'h55: expected RX_DATA word at a good sampling point.

Ports:
- FAB_CLK  in  1  fabric clock, same clock as the IOD RX_CLK.
- ARST_N  in  1  asynchronous active-low reset.
- TRAIN_START  in  1  level; sampled only in IDLE.
- RX_DATA  in  8  deserialised lane data from the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  delay-line limit flag from the IOD.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; returns the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid whenever MOVE is high.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse after each load or move.
- TRAIN_BUSY  out  1  high in every state except IDLE, DONE and FAIL.
- TRAIN_DONE  out  1  sticky success flag.
- TRAIN_FAIL  out  1  sticky failure flag.
- FINAL_TAP  out  8  tap selected at the window centre.
- WINDOW_WIDTH  out  8  number of taps in the selected window.

Behaviour:
- Reset: ARST_N low asynchronously forces the FSM to IDLE and clears every output and internal register to 0.
- Reset mid-sweep: the FSM aborts with no further pulses; the delay-line position is not restored.
- All outputs are registered.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, CENTER, DONE, FAIL.
- IDLE: when TRAIN_START=1, go to LOAD and clear tap, window and status registers.
- LOAD: assert DELAY_LINE_LOAD for 1 cycle; tap=0; go to SETTLE.
- SETTLE:
  - Pulse EYE_MONITOR_CLEAR_FLAGS in the first cycle.
  - Wait SETTLE_CYCLES cycles in total.
  - Go to SAMPLE, or to CENTER if the settle followed a centring move.
- SAMPLE:
  - Runs exactly SAMPLE_COUNT cycles.
  - pass starts at 1 and is cleared on any RX_DATA != PATTERN.
  - Go to EVAL.
- EVAL (1 cycle), window tracking:
  - pass and no window open: open a window, cur_start=tap.
  - pass and window open: extend it, cur_end=tap.
  - fail and window open: close it.
  - On close: if cur_end-cur_start+1 is strictly greater than the best width, it becomes best; on a tie the earlier window is kept.
- STEP:
  - If tap==MAX_TAPS-1 or DELAY_LINE_OUT_OF_RANGE=1: close any open window under the same rule, then go to CENTER.
  - Otherwise: MOVE=1 and DIRECTION=1 for 1 cycle, tap=tap+1, go to SETTLE.
- CENTER entry:
  - No window recorded: go to FAIL.
  - Otherwise target = (best_start+best_end)>>1, computed with a 9-bit intermediate and floor rounding.
- CENTER stepping:
  - While tap>target: MOVE=1, DIRECTION=0 for 1 cycle, tap=tap-1, then SETTLE (no SAMPLE).
  - Hence at most one MOVE every SETTLE_CYCLES+2 cycles.
  - When tap==target: go to DONE.
- DONE: TRAIN_DONE=1, FINAL_TAP=target, WINDOW_WIDTH=best width; TRAIN_BUSY=0.
- FAIL: TRAIN_FAIL=1, FINAL_TAP=0, WINDOW_WIDTH=0.
- Leaving DONE/FAIL: both hold until TRAIN_START is sampled 0 and then 1 again (rising edge). On that edge, clear DONE/FAIL and go to LOAD. A level held high does not retrigger.
- Pulse exclusivity: LOAD and MOVE are never high together. Every MOVE pulse is followed by at least SETTLE_CYCLES cycles before the next MOVE.
- Width rules:
  - tap and best/cur start/end registers are 8 bits.
  - A width of 256 (MAX_TAPS=256 with all taps passing) saturates WINDOW_WIDTH to 255.
- Simultaneous events: OUT_OF_RANGE arriving on the same cycle as a pass still has that tap evaluated first, because EVAL precedes STEP.

Test Plan:
- Lane model passes taps 20..40 only (defaults):
  - 1 LOAD and 127 increment MOVEs.
  - Then 97 decrement MOVEs.
  - TRAIN_DONE=1, FINAL_TAP=30, WINDOW_WIDTH=21.
  - Exactly 128+97 EYE_MONITOR_CLEAR_FLAGS pulses.
- Passing windows 5..9 and 60..69:
  - FINAL_TAP=64, WINDOW_WIDTH=10.
  - Equal windows 5..9 and 60..64 instead: FINAL_TAP=7, WINDOW_WIDTH=5 (earlier window wins the tie).
- No tap passes, or a single corrupted word per tap: TRAIN_FAIL=1, TRAIN_DONE=0, FINAL_TAP=0 after 127 increment MOVEs.
- Window 100..127 still open at the end of the sweep: window closed at the end, FINAL_TAP=113, WINDOW_WIDTH=28.
- DELAY_LINE_OUT_OF_RANGE forced high at tap 50 with window 30..50:
  - No increment MOVE beyond tap 50.
  - FINAL_TAP=40, WINDOW_WIDTH=21.
- ARST_N pulsed low during SAMPLE at tap 70:
  - All outputs 0 immediately, with no further pulses.
  - A TRAIN_START rising edge after release reruns the sweep, starting with a LOAD.
  - TRAIN_START held high through DONE does not retrigger.
